// File: rtl/m_spi_master.sv
// rtl/m_spi_master.sv - parametrised full-duplex SPI master
// One CLK_DIV tick counter paces LEAD, every SCLK edge and TRAIL; all outputs are registered.
module m_spi_master #(
  parameter int WIDTH   = 64,
  parameter int CLK_DIV = 4,
  parameter int NUM_SS  = 1,
  parameter int SEL_W   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  tx_data,
  input  logic [1:0]        mode,
  input  logic              lsb_first,
  input  logic [SEL_W-1:0]  ss_sel,
  output logic [WIDTH-1:0]  rx_data,
  output logic              status,
  output logic              done,
  output logic              SCLK_MASTER,
  output logic [NUM_SS-1:0] SS_N_MASTER,
  output logic              MOSI_MASTER,
  input  logic              MISO_MASTER
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LEAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_TRAIL = 2'd3;

  localparam int CNT_W  = $clog2(CLK_DIV + 1);
  localparam int EDGE_W = $clog2(2 * WIDTH + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * WIDTH);
  localparam logic [CNT_W-1:0]  TICK_CNT  = CNT_W'(CLK_DIV);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [WIDTH-1:0]  tx_q, tx_d;
  logic [WIDTH-1:0]  rx_q, rx_d;
  logic [WIDTH-1:0]  rx_data_q, rx_data_d;
  logic [1:0]        mode_q, mode_d;
  logic              lsb_q, lsb_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              status_q, status_d;
  logic              done_q, done_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic              tick, accept, busy;
  logic [EDGE_W-1:0] edge_n;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    mode_d    = mode_q;
    lsb_d     = lsb_q;
    sel_d     = sel_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    tick      = (cnt_q == TICK_CNT);
    edge_n    = edge_q + EDGE_W'(1);
    accept    = 1'b0;
    busy      = 1'b0;

    case (state_q)
      S_IDLE: begin
        sclk_d = mode[1];
        accept = start;
      end
      S_LEAD, S_SHIFT: begin
        busy  = 1'b1;
        cnt_d = tick ? CNT_W'(1) : cnt_q + CNT_W'(1);
        if (tick) begin
          edge_d  = edge_n;
          sclk_d  = ~sclk_q;
          state_d = (edge_n == LAST_EDGE) ? S_TRAIL : S_SHIFT;
          // Odd edges lead; CPHA selects whether leading or trailing edges sample.
          if (edge_n[0] ^ mode_q[0]) begin
            rx_d = lsb_q ? {MISO_MASTER, rx_q[WIDTH-1:1]} : {rx_q[WIDTH-2:0], MISO_MASTER};
          end else if (edge_n != LAST_EDGE) begin
            mosi_d = lsb_q ? tx_q[0] : tx_q[WIDTH-1];
            tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
          end
        end
      end
      default: begin
        sclk_d = mode_q[1];
        cnt_d  = cnt_q + CNT_W'(1);
        busy   = ~tick;
        if (tick) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          rx_data_d = rx_q;
          accept    = start;
        end
      end
    endcase

    // Accepting in the completion cycle keeps SS_N high for exactly one cycle between words.
    if (accept) begin
      state_d = S_LEAD;
      cnt_d   = '0;
      edge_d  = '0;
      mode_d  = mode;
      lsb_d   = lsb_first;
      sel_d   = ss_sel;
      sclk_d  = mode[1];
      tx_d    = tx_data;
      if (!mode[0]) begin
        mosi_d = lsb_first ? tx_data[0] : tx_data[WIDTH-1];
        tx_d   = lsb_first ? (tx_data >> 1) : (tx_data << 1);
      end
    end

    status_d = busy;
    for (int i = 0; i < NUM_SS; i++) begin
      ss_n_d[i] = ~(busy && (sel_q == SEL_W'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert ((1 << SEL_W) >= NUM_SS);
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      edge_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      mode_q    <= '0;
      lsb_q     <= 1'b0;
      sel_q     <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      status_q  <= 1'b0;
      done_q    <= 1'b0;
      ss_n_q    <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      mode_q    <= mode_d;
      lsb_q     <= lsb_d;
      sel_q     <= sel_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      status_q  <= status_d;
      done_q    <= done_d;
      ss_n_q    <= ss_n_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign status      = status_q;
  assign done        = done_q;
  assign SCLK_MASTER = sclk_q;
  assign SS_N_MASTER = ss_n_q;
  assign MOSI_MASTER = mosi_q;

endmodule

// File: tb/tb_m_spi_master.sv
// tb/tb_m_spi_master.sv - self-checking bench for m_spi_master
// Vector table plus scoreboard popped on done; behavioural SPI slave supplies MISO.
module tb_m_spi_master;
  localparam int W          = 8;
  localparam int DIV        = 2;
  localparam int N_SS       = 4;
  localparam int N_EDGES    = 2 * W;
  localparam int FIRST_EDGE = 1 + DIV;
  localparam int LAST_EDGE  = 1 + 2 * W * DIV;
  localparam int DONE_CYC   = 1 + (2 * W + 1) * DIV;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [W-1:0]    tx_data = '0;
  logic [1:0]      mode = 2'b00;
  logic            lsb_first = 1'b0;
  logic [1:0]      ss_sel = 2'd0;
  logic [W-1:0]    rx_data;
  logic            status;
  logic            done;
  logic            sclk;
  logic [N_SS-1:0] ss_n;
  logic            mosi;
  logic            miso;
  logic            loop = 1'b0;
  logic            slv_out = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  assign miso = loop ? mosi : slv_out;

  m_spi_master #(.WIDTH(W), .CLK_DIV(DIV), .NUM_SS(N_SS), .SEL_W(2)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .mode(mode),
    .lsb_first(lsb_first), .ss_sel(ss_sel), .rx_data(rx_data), .status(status),
    .done(done), .SCLK_MASTER(sclk), .SS_N_MASTER(ss_n), .MOSI_MASTER(mosi),
    .MISO_MASTER(miso)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t exceeded limit 100000", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // SPI slave: drives its word and captures MOSI according to its own CPOL/CPHA view.
  logic [W-1:0] slv_word = '0;
  logic [W-1:0] slv_got = '0;
  logic [1:0]   slv_mode = 2'b00;
  logic         slv_lsb = 1'b0;
  int           slv_k = 0;
  logic         ss_prev = 1'b0;
  logic         sclk_prev = 1'b0;
  logic         ss_act;
  assign ss_act = ~&ss_n;

  function automatic logic slv_bit(input int k);
    return slv_lsb ? slv_word[k] : slv_word[W-1-k];
  endfunction

  always @(sclk or ss_act) begin
    if (ss_act && !ss_prev) begin
      slv_got = '0;
      slv_k   = 0;
      if (!slv_mode[0]) begin
        slv_out = slv_bit(0);
        slv_k   = 1;
      end
    end else if (ss_act && (sclk != sclk_prev)) begin
      if ((sclk != slv_mode[1]) != slv_mode[0]) begin
        slv_got = slv_lsb ? {mosi, slv_got[W-1:1]} : {slv_got[W-2:0], mosi};
      end else if (slv_k < W) begin
        slv_out = slv_bit(slv_k);
        slv_k++;
      end
    end
    ss_prev   = ss_act;
    sclk_prev = sclk;
  end

  typedef struct {
    logic [W-1:0] rx;
    logic [W-1:0] slv;
    logic         chk_slv;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: done=1 at %0t, expected no completion", $time);
      end else begin
        e = sb.pop_front();
        chk("rx_data", rx_data, e.rx);
        if (e.chk_slv) chk("slave_rx", slv_got, e.slv);
      end
    end
  end

  typedef struct {
    logic [1:0]    mode;
    logic          lsb;
    logic [1:0]    sel;
    logic [W-1:0]  tx;
    logic [W-1:0]  slv;
    logic          loop;
    logic          restart;
    logic [W-1:0]  exp_rx;
    logic [N_SS-1:0] ss_exp;
    int            mosi_hi;
  } vec_t;
  vec_t vecs [8];

  task automatic run_vec(input vec_t v);
    int   toggles, first_t, last_t, done_c, mosi_hi;
    logic prev_sclk;
    logic [N_SS-1:0] ss1;
    @(negedge clk);
    mode = v.mode; lsb_first = v.lsb; ss_sel = v.sel; tx_data = v.tx;
    slv_word = v.slv; slv_mode = v.mode; slv_lsb = v.lsb; loop = v.loop;
    start = 1'b1;
    sb.push_back('{v.exp_rx, v.tx, !v.loop});
    toggles = 0; first_t = -1; last_t = -1; done_c = -1; mosi_hi = 0;
    prev_sclk = 1'b0; ss1 = '0;
    for (int c = 0; c < 200 && done_c < 0; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start = 1'b0;
        prev_sclk = sclk;
        chk("sclk_idle_before", sclk, v.mode[1]);
      end else begin
        if (sclk != prev_sclk) begin
          toggles++;
          if (first_t < 0) first_t = c;
          last_t = c;
        end
        prev_sclk = sclk;
        if (c == 1) ss1 = ss_n;
        if (done) done_c = c;
      end
      if (mosi) mosi_hi++;
      if (v.restart && c == 10) start = 1'b1;
      if (v.restart && c == 11) start = 1'b0;
    end
    chk("ss_select_pattern", ss1, v.ss_exp);
    chk("sclk_edge_count", toggles, N_EDGES);
    chk("first_sclk_edge_cycle", first_t, FIRST_EDGE);
    chk("last_sclk_edge_cycle", last_t, LAST_EDGE);
    chk("done_cycle", done_c, DONE_CYC);
    chk("sclk_idle_after", sclk, v.mode[1]);
    chk("status_at_done", status, 1'b0);
    if (v.mosi_hi >= 0) chk("mosi_high_cycles", mosi_hi, v.mosi_hi);
    repeat (3) @(negedge clk);
    chk("status_after_done", status, 1'b0);
  endtask

  initial begin
    int   tog, dcount;
    logic prev;
    logic ssa [0:79];
    logic dn  [0:79];

    vecs[0] = '{2'b00, 1'b0, 2'd0, 8'hA5, 8'h00, 1'b1, 1'b0, 8'hA5, 4'b1110, -1};
    vecs[1] = '{2'b00, 1'b0, 2'd2, 8'h12, 8'hBE, 1'b0, 1'b0, 8'hBE, 4'b1011, -1};
    vecs[2] = '{2'b01, 1'b0, 2'd3, 8'h12, 8'hBE, 1'b0, 1'b0, 8'hBE, 4'b0111, -1};
    vecs[3] = '{2'b10, 1'b0, 2'd1, 8'h12, 8'hBE, 1'b0, 1'b0, 8'hBE, 4'b1101, -1};
    vecs[4] = '{2'b11, 1'b0, 2'd0, 8'h12, 8'hBE, 1'b0, 1'b0, 8'hBE, 4'b1110, -1};
    vecs[5] = '{2'b00, 1'b1, 2'd0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h01, 4'b1110, 5};
    vecs[6] = '{2'b11, 1'b1, 2'd2, 8'hC3, 8'h5A, 1'b0, 1'b0, 8'h5A, 4'b1011, -1};
    vecs[7] = '{2'b01, 1'b0, 2'd3, 8'h3C, 8'h81, 1'b0, 1'b1, 8'h81, 4'b0111, -1};

    repeat (3) @(negedge clk);
    chk("reset_ss_n", ss_n, 4'hF);
    chk("reset_status", status, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_sclk", sclk, 1'b0);
    chk("reset_mosi", mosi, 1'b0);
    chk("reset_rx_data", rx_data, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Back-to-back: start held high across the completion edge.
    @(negedge clk);
    mode = 2'b00; lsb_first = 1'b0; ss_sel = 2'd0; tx_data = 8'h5C; loop = 1'b1;
    start = 1'b1;
    sb.push_back('{8'h5C, 8'h00, 1'b0});
    sb.push_back('{8'h5C, 8'h00, 1'b0});
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      ssa[c] = ss_act;
      dn[c]  = done;
      if (c == 40) start = 1'b0;
    end
    chk("b2b_ss_active_before_gap", ssa[34], 1'b1);
    chk("b2b_ss_gap", ssa[35], 1'b0);
    chk("b2b_ss_active_after_gap", ssa[36], 1'b1);
    chk("b2b_done_early", dn[34], 1'b0);
    chk("b2b_done_first", dn[35], 1'b1);
    chk("b2b_done_first_width", dn[36], 1'b0);
    chk("b2b_done_second", dn[70], 1'b1);
    chk("b2b_done_second_width", dn[71], 1'b0);
    chk("b2b_ss_idle_end", ssa[79], 1'b0);

    // Reset after SCLK edge 5 of a transfer: no completion, everything cleared.
    @(negedge clk);
    mode = 2'b01; lsb_first = 1'b0; ss_sel = 2'd1; tx_data = 8'hFF; loop = 1'b1;
    slv_mode = 2'b01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev = sclk;
    tog = 0;
    for (int c = 0; c < 100 && tog < 5; c++) begin
      @(negedge clk);
      if (sclk != prev) tog++;
      prev = sclk;
    end
    chk("abort_reached_edge5", tog, 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ss_n", ss_n, 4'hF);
    chk("abort_sclk", sclk, 1'b0);
    chk("abort_mosi", mosi, 1'b0);
    chk("abort_status", status, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_rx_data", rx_data, 8'h00);
    dcount = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", dcount, 0);

    run_vec(vecs[1]);

    // start coincident with reset must not launch a transfer.
    @(negedge clk);
    mode = 2'b00; start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    chk("start_reset_status", status, 1'b0);
    @(negedge clk);
    chk("start_reset_status_next", status, 1'b0);
    chk("start_reset_ss_n", ss_n, 4'hF);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
